// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_rr
//  Description : Round-robin block-transfer arbiter. Each grant moves one
//                whole cache block (fill or write-back) as a sequence of
//                32-bit beats over a single-beat bus adapter, with optional
//                per-beat byte reversal.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
    parameter int NUM_CH     = 2,
    parameter int BLOCK_SIZE = 32,
    parameter int BYTE_SWAP  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                ch_req,
    input  logic [NUM_CH-1:0]                ch_write,
    input  logic [NUM_CH*32-1:0]             ch_addr,
    input  logic [NUM_CH*BLOCK_SIZE*8-1:0]   ch_wdata,
    output logic [BLOCK_SIZE*8-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]                ch_done,
    output logic [NUM_CH-1:0]                ch_busy,
    output logic                             bus_valid,
    output logic [31:0]                      bus_addr,
    output logic                             bus_write,
    output logic [31:0]                      bus_wdata,
    output logic [2:0]                       bus_size,
    input  logic [31:0]                      bus_rdata,
    input  logic                             bus_ready
);

    localparam int NB     = BLOCK_SIZE / 4;
    localparam int WIDX_W = $clog2(NB);
    localparam int BEAT_W = WIDX_W + 1;
    localparam int GNT_W  = $clog2(NUM_CH);
    localparam int BLK_W  = BLOCK_SIZE * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GNT_W-1:0]    r_grant;
    logic [GNT_W-1:0]    r_last;
    logic [GNT_W-1:0]    w_pick;
    logic                w_any;
    logic                r_write;
    logic [31:0]         r_base;
    logic [BEAT_W-1:0]   r_beat;
    logic [WIDX_W-1:0]   w_word;
    logic                w_last_beat;
    logic [31:0]         r_blk [NB];
    logic [31:0]         r_buf [NB];
    logic [31:0]         w_addr [NUM_CH];
    logic [31:0]         w_wblk [NUM_CH][NB];

    function automatic logic [31:0] swap32(input logic [31:0] d);
        if (BYTE_SWAP != 0) return {d[7:0], d[15:8], d[23:16], d[31:24]};
        return d;
    endfunction

    // Split the flat channel buses into per-channel address and block words.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_unpack
        assign w_addr[c] = ch_addr[c*32 +: 32];
        for (genvar k = 0; k < NB; k++) begin : g_word
            assign w_wblk[c][k] = ch_wdata[c*BLK_W + k*32 +: 32];
        end
    end

    assign w_word      = r_beat[WIDX_W-1:0];
    assign w_last_beat = (r_beat == BEAT_W'(NB - 1));

    // Pick the first requester at or after last+1, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_any && ch_req[(int'(r_last) + i) % NUM_CH]) begin
                w_any  = 1'b1;
                w_pick = GNT_W'((int'(r_last) + i) % NUM_CH);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode: a burst ends only when its last beat is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_BURST;
            ST_BURST: if (bus_ready && w_last_beat) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant capture, beat counting and fill-buffer updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant <= '0;
            r_last  <= GNT_W'(NUM_CH - 1);
            r_write <= 1'b0;
            r_base  <= '0;
            r_beat  <= '0;
            for (int k = 0; k < NB; k++) begin
                r_blk[k] <= '0;
                r_buf[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_write <= ch_write[w_pick];
                        // Block-aligned base so beat offsets never carry.
                        r_base  <= w_addr[w_pick] & ~32'(BLOCK_SIZE - 1);
                        r_beat  <= '0;
                        for (int k = 0; k < NB; k++) r_blk[k] <= w_wblk[w_pick][k];
                    end
                end
                ST_BURST: begin
                    if (bus_ready) begin
                        r_beat <= r_beat + 1'b1;
                        if (!r_write) r_buf[w_word] <= swap32(bus_rdata);
                    end
                end
                ST_DONE: r_last <= r_grant;
                default: ;
            endcase
        end
    end

    // Bus outputs decode registered state only.
    assign bus_valid = (r_state == ST_BURST);
    assign bus_addr  = bus_valid ? (r_base | {{(30-WIDX_W){1'b0}}, w_word, 2'b00}) : 32'd0;
    assign bus_write = bus_valid & r_write;
    assign bus_wdata = bus_valid ? swap32(r_blk[w_word]) : 32'd0;
    assign bus_size  = bus_valid ? 3'b010 : 3'b000;

    for (genvar k = 0; k < NB; k++) begin : g_rdata
        assign ch_rdata[k*32 +: 32] = r_buf[k];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_status
        assign ch_done[c] = (r_state == ST_DONE) && (r_grant == GNT_W'(c));
        assign ch_busy[c] = (r_state != ST_IDLE) && (r_grant == GNT_W'(c));
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_rr
//  Description : Self-checking bench for mem_arbiter_rr (4 channels,
//                32-byte blocks, byte swap on).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

    logic          clk;
    logic          rst;
    logic [3:0]    ch_req;
    logic [3:0]    ch_write;
    logic [127:0]  ch_addr;
    logic [1023:0] ch_wdata;
    logic [255:0]  ch_rdata;
    logic [3:0]    ch_done;
    logic [3:0]    ch_busy;
    logic          bus_valid;
    logic [31:0]   bus_addr;
    logic          bus_write;
    logic [31:0]   bus_wdata;
    logic [2:0]    bus_size;
    logic [31:0]   bus_rdata;
    logic          bus_ready;
    logic [31:0]   rd_seed;

    int tests = 0;
    int fails = 0;
    logic [255:0] exp_rdata;

    typedef struct {
        int          ch;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] base;
        logic [31:0] seed;
        int          stall_beat;
        int          stall_n;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    mem_arbiter_rr #(.NUM_CH(4), .BLOCK_SIZE(32), .BYTE_SWAP(1)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
        .ch_done(ch_done), .ch_busy(ch_busy), .bus_valid(bus_valid),
        .bus_addr(bus_addr), .bus_write(bus_write), .bus_wdata(bus_wdata),
        .bus_size(bus_size), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    // Memory model: word k of a block reads back as seed + k.
    assign bus_rdata = rd_seed + {29'd0, bus_addr[4:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] wword(input int c, input int k);
        if (c == 1) return 32'(k);
        return 32'h5A00_0000 + 32'(c * 256 + k);
    endfunction

    function automatic logic [3:0] onehot(input int c);
        return 4'd1 << c;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ch_req = '0;
        bus_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_done(output int c, output int cyc);
        c = -1;
        cyc = 0;
        while (c < 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            for (int k = 0; k < 4; k++) if (ch_done[k]) c = k;
        end
        if (c < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no ch_done expected a pulse");
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc, beat, stalls;
        bit  done_seen;
        ch_write[v.ch] = v.wr;
        ch_addr[v.ch*32 +: 32] = v.addr;
        rd_seed = v.seed;
        bus_ready = 1'b1;
        ch_req[v.ch] = 1'b1;
        cyc = 0; beat = 0; stalls = 0; done_seen = 0;
        while (!done_seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (ch_done != 4'd0) begin
                done_seen = 1;
                chk("done_ch", ch_done, onehot(v.ch));
                chk("done_latency", cyc, v.lat);
                chk("beat_count", beat, 8);
                if (!v.wr)
                    for (int k = 0; k < 8; k++) exp_rdata[k*32 +: 32] = swap(v.seed + 32'(k));
                chk("ch_rdata", ch_rdata, exp_rdata);
                ch_req[v.ch] = 1'b0;
            end else if (bus_valid) begin
                chk("bus_addr", bus_addr, v.base + 32'(4 * beat));
                chk("bus_write", bus_write, v.wr);
                chk("bus_size", bus_size, 3'b010);
                chk("ch_busy", ch_busy, onehot(v.ch));
                if (v.wr) chk("bus_wdata", bus_wdata, swap(wword(v.ch, beat)));
                if (beat == v.stall_beat && stalls < v.stall_n) begin
                    bus_ready = 1'b0;
                    stalls++;
                end else begin
                    bus_ready = 1'b1;
                    beat++;
                end
            end
        end
        if (!done_seen) begin
            tests++;
            fails++;
            $display("FAIL vec_timeout: got no ch_done expected one for ch%0d", v.ch);
        end
        bus_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic rr_seq(input logic [3:0] mask, input int exp_order[5], input int n);
        int c, cyc;
        do_reset();
        ch_write = '0;
        ch_req = mask;
        for (int i = 0; i < n; i++) begin
            wait_done(c, cyc);
            chk("rr_grant", c, exp_order[i]);
            chk("rr_spacing", cyc, (i == 0) ? 9 : 10);
        end
        ch_req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int  c, cyc;
        bit  early_done;
        rst = 1'b0; ch_req = '0; ch_write = '0; ch_addr = '0;
        bus_ready = 1'b1; rd_seed = '0; exp_rdata = '0;
        for (int cc = 0; cc < 4; cc++)
            for (int k = 0; k < 8; k++) ch_wdata[cc*256 + k*32 +: 32] = wword(cc, k);

        vecs[0] = '{0, 1'b0, 32'h1000_0014, 32'h1000_0000, 32'hAABB_CCDD, -1, 0, 9};
        vecs[1] = '{1, 1'b1, 32'h2000_0040, 32'h2000_0040, 32'h0,         -1, 0, 9};
        vecs[2] = '{2, 1'b0, 32'h3000_003F, 32'h3000_0020, 32'h0102_0304, -1, 0, 9};
        vecs[3] = '{3, 1'b0, 32'h0000_FFFC, 32'h0000_FFE0, 32'hF0E0_D0C0,  2, 3, 12};
        vecs[4] = '{0, 1'b1, 32'h4000_001C, 32'h4000_0000, 32'h0,          2, 3, 12};
        vecs[5] = '{2, 1'b1, 32'h5000_0000, 32'h5000_0000, 32'h0,          7, 2, 11};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ch_rdata", ch_rdata, 256'd0);
        chk("rst_ch_done", ch_done, 4'd0);
        chk("rst_ch_busy", ch_busy, 4'd0);
        chk("rst_bus_valid", bus_valid, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_write", bus_write, 1'b0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_size", bus_size, 3'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Fairness: two and four continuous requesters.
        rr_seq(4'b0011, '{0, 1, 0, 1, 0}, 4);
        rr_seq(4'b1111, '{0, 1, 2, 3, 0}, 5);

        // Request dropped at beat 3 must not cut the burst short.
        ch_write = '0;
        ch_addr[31:0] = 32'h1000_0014;
        rd_seed = 32'h1122_3344;
        ch_req = 4'b0001;
        repeat (4) @(posedge clk);
        #1;
        chk("drop_beat3_addr", bus_addr, 32'h1000_000C);
        ch_req = 4'b0000;
        wait_done(c, cyc);
        chk("drop_done_ch", c, 0);
        chk("drop_done_latency", cyc, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("drop_no_regrant", bus_valid, 1'b0);

        // Reset pulsed at beat 5 of a ch1 fill; ch0 must win afterwards.
        ch_req = 4'b0011;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid_busy", ch_busy, 4'b0010);
        chk("rst_mid_addr", bus_addr, 32'h2000_0054);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", bus_valid, 1'b0);
        chk("rst_mid_busy_clr", ch_busy, 4'd0);
        chk("rst_mid_done", ch_done, 4'd0);
        @(posedge clk); #1;
        chk("rst_mid_rdata", ch_rdata, 256'd0);
        rst = 1'b1;
        early_done = 0;
        cyc = 0;
        while (!bus_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (ch_done != 4'd0) early_done = 1;
        end
        chk("rst_no_done", early_done, 1'b0);
        chk("rst_regrant_ch0", ch_busy, 4'b0001);
        wait_done(c, cyc);
        chk("rst_regrant_done", c, 0);
        ch_req = '0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Multi-channel, round-robin block-transfer arbiter between the cache controllers (I-cache, D-cache, and optionally DMA/debug) and the single-beat AHB adapter. Each granted request moves one full cache block as a sequence of 32-bit beats. Reads are line fills and writes are block write-backs. Endianness swapping is optional per beat. It generalises the fixed two-port, read-only, fixed-priority block-fill arbiter to N channels with fair arbitration and write-back support.

## Interface
- NUM_CH, 2: number of requesting channels (2..4).
- BLOCK_SIZE, 32: block size in bytes (16, 32 or 64); NB = BLOCK_SIZE/4 beats.
- BYTE_SWAP, 1: 1 = reverse the byte order of every 32-bit beat in both directions.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_req  in  NUM_CH  level request per channel; held until that channel's ch_done.
- ch_write  in  NUM_CH  1 = block write-back, 0 = block fill.
- ch_addr  in  NUM_CH*32  byte address; channel i at [i*32 +: 32].
- ch_wdata  in  NUM_CH*BLOCK_SIZE*8  write-back block; channel i at [i*BLOCK_SIZE*8 +: BLOCK_SIZE*8].
- ch_rdata  out  BLOCK_SIZE*8  shared fill data; valid while ch_done is high and held afterwards.
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel.
- ch_busy  out  NUM_CH  high while the channel is granted (BURST and DONE).
- bus_valid  out  1  beat request to the AHB adapter.
- bus_addr  out  32  beat address.
- bus_write  out  1  beat direction.
- bus_wdata  out  32  beat write data.
- bus_size  out  3  constant 3'b010 (word) while bus_valid is high, else 0.
- bus_rdata  in  32  beat read data; valid with bus_ready on a read beat.
- bus_ready  in  1  completes the current beat when high with bus_valid.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If any ch_req is high, grant the first requesting channel at or after (last+1) mod NUM_CH.
  - Latch the grant index, ch_write, the block-aligned base (ch_addr with bits [log2(BLOCK_SIZE)-1:0] cleared) and ch_wdata.
  - Clear the beat counter and go to BURST.
- BURST:
  - bus_valid = 1, bus_addr = base + 4*beat, bus_write = latched write.
  - bus_wdata = block word [beat*32 +: 32], swapped if BYTE_SWAP.
  - On bus_ready on a read, write the (swapped) bus_rdata into buffer word [beat*32 +: 32]; beat 0 is the least significant word.
  - On bus_ready, beat increments. On bus_ready at beat == NB-1, go to DONE.
- DONE:
  - ch_done[grant] = 1 for this cycle only; last = grant; go to IDLE.
  - ch_rdata drives the buffer. A write burst leaves the buffer unchanged.
- Requests are sampled only in IDLE. A ch_req drop mid-burst does not abort the burst, and the burst completes in full.
- A requester deasserts ch_req in the cycle after ch_done. Requests still pending in IDLE are re-arbitrated using the updated pointer.
- The beat counter is log2(NB)+1 bits wide. The address increment never carries past the block boundary (block-aligned base).
- ch_addr low bits are ignored; fills and write-backs are always whole blocks.

## Timing
- Reset values: state = IDLE, last = NUM_CH-1 (so channel 0 wins first), beat = 0, buffer = 0.
- Output reset values: ch_rdata = 0, ch_done = 0, ch_busy = 0, bus_valid = 0, bus_addr = 0, bus_write = 0, bus_wdata = 0, bus_size = 0.
- Reset asserted mid-burst returns to IDLE immediately and drops bus_valid. No ch_done is issued for the aborted burst.
- Latency with bus_ready tied high, ch_req rising before edge E0:
  - BURST occupies cycles E0+1..E0+NB.
  - ch_done is high in cycle E0+NB+1.
  - The earliest next grant is at edge E0+NB+2.
- Each bus_ready-low cycle stretches the burst by exactly one cycle. bus_addr, bus_write and bus_wdata are held stable while bus_valid is high and bus_ready is low.
- bus outputs are registered state decodes; there is no combinational path from ch_req to the bus.
- There is at least one IDLE cycle between consecutive bursts.

## Test plan
- Single fill, NUM_CH=2, BLOCK_SIZE=32, BYTE_SWAP=1:
  - Stimulus: ch0 reads 0x1000_0014; the bus returns 0xAABBCCDD+k on beat k.
  - Required: bus_addr runs 0x1000_0000..0x1000_001C, ch_done[0] pulses at cycle 9, and word k = byte-swap(0xAABBCCDD+k).
- Write-back:
  - Stimulus: ch1 writes with ch_wdata word k = k.
  - Required: 8 beats with bus_write = 1, bus_wdata = swap(k), ch_done[1] = 1, and ch_rdata unchanged.
- Round-robin:
  - Stimulus: ch0 and ch1 both requesting continuously.
  - Required: grants alternate 0,1,0,1. With NUM_CH=4 and all requesting, the grant order is 0,1,2,3,0.
- Wait states:
  - Stimulus: bus_ready low for 3 cycles on beat 2.
  - Required: beat-2 address and data are held, and ch_done is delayed by exactly 3 cycles.
- Mid-burst events:
  - ch0 drops ch_req at beat 3: the burst still completes all 8 beats.
  - rst is pulsed at beat 5: bus_valid = 0 immediately, no ch_done, and the next grant goes to ch0.
